// File: rtl/funnel_fanout_buffered.sv
// One-to-many distributor: each accepted word is routed by its lane index into a
// small per-lane FIFO; out-of-range indices are consumed, counted and discarded.
module funnel_fanout_buffered #(
  parameter int WIDTH        = 32,
  parameter int FUNNEL_WIDTH = 4,
  parameter int IDX_WIDTH    = 2,
  parameter int DEPTH        = 2
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          in_enq__ENA,
  input  logic [WIDTH-1:0]              in_enq_v,
  input  logic [IDX_WIDTH-1:0]          in_enq_index,
  output logic                          in_enq__RDY,
  output logic [FUNNEL_WIDTH-1:0]       out_enq__ENA,
  output logic [FUNNEL_WIDTH*WIDTH-1:0] out_enq_v,
  input  logic [FUNNEL_WIDTH-1:0]       out_enq__RDY,
  output logic                          dropped,
  output logic [15:0]                   drop_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDXP_W = IDX_WIDTH + 1;
  localparam logic [PTR_W-1:0]  LAST_PTR  = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(DEPTH);
  localparam logic [IDXP_W-1:0] NUM_LANES = IDXP_W'(FUNNEL_WIDTH);

  logic [WIDTH-1:0] mem_r    [FUNNEL_WIDTH][DEPTH];
  logic [PTR_W-1:0] rd_ptr_r [FUNNEL_WIDTH];
  logic [PTR_W-1:0] wr_ptr_r [FUNNEL_WIDTH];
  logic [CNT_W-1:0] cnt_r    [FUNNEL_WIDTH];
  logic             dropped_r;
  logic [15:0]      drop_count_r;

  logic                    full_any_s;
  logic                    take_s;
  logic                    in_range_s;
  logic                    drop_s;
  logic [FUNNEL_WIDTH-1:0] push_s;
  logic [FUNNEL_WIDTH-1:0] pop_s;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? PTR_W'(0) : p + PTR_W'(1);
  endfunction

  // Guard uses occupancy only, so it never depends on the offered word or index.
  always_comb begin
    full_any_s = 1'b0;
    pop_s      = '0;
    push_s     = '0;
    in_range_s = ({1'b0, in_enq_index} < NUM_LANES);
    take_s     = in_enq__ENA & ~full_any_s & ~RST;
    for (int i = 0; i < FUNNEL_WIDTH; i++) begin
      full_any_s = full_any_s | (cnt_r[i] == FULL_CNT);
    end
    take_s = in_enq__ENA & ~full_any_s & ~RST;
    drop_s = take_s & ~in_range_s;
    for (int i = 0; i < FUNNEL_WIDTH; i++) begin
      push_s[i] = take_s & in_range_s & (in_enq_index == IDX_WIDTH'(i));
      pop_s[i]  = (cnt_r[i] != CNT_W'(0)) & out_enq__RDY[i] & ~RST;
    end
  end

  assign in_enq__RDY  = RST | ~full_any_s;
  assign out_enq__ENA = pop_s;
  assign dropped      = dropped_r;
  assign drop_count   = drop_count_r;

  genvar g;
  for (g = 0; g < FUNNEL_WIDTH; g++) begin : g_lane_out
    assign out_enq_v[g*WIDTH +: WIDTH] = mem_r[g][rd_ptr_r[g]];
  end

  // Lane FIFOs and drop bookkeeping; a lane popped while empty cannot happen since pop needs count != 0.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < FUNNEL_WIDTH; i++) begin
        rd_ptr_r[i] <= PTR_W'(0);
        wr_ptr_r[i] <= PTR_W'(0);
        cnt_r[i]    <= CNT_W'(0);
      end
      dropped_r    <= 1'b0;
      drop_count_r <= 16'd0;
    end else begin
      for (int i = 0; i < FUNNEL_WIDTH; i++) begin
        if (push_s[i]) begin
          mem_r[i][wr_ptr_r[i]] <= in_enq_v;
          wr_ptr_r[i]           <= next_ptr(wr_ptr_r[i]);
        end
        if (pop_s[i]) begin
          rd_ptr_r[i] <= next_ptr(rd_ptr_r[i]);
        end
        case ({push_s[i], pop_s[i]})
          2'b10:   cnt_r[i] <= cnt_r[i] + CNT_W'(1);
          2'b01:   cnt_r[i] <= cnt_r[i] - CNT_W'(1);
          default: cnt_r[i] <= cnt_r[i];
        endcase
      end
      dropped_r <= drop_s;
      if (drop_s && (drop_count_r != 16'hFFFF)) begin
        drop_count_r <= drop_count_r + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_funnel_fanout_buffered.sv
// Scoreboard bench: expected words are queued per lane at enqueue and popped
// by a negedge monitor whenever a lane strobes its output.
module tb_funnel_fanout_buffered;

  logic         CLK;
  logic         RST;
  logic         in_ena;
  logic [31:0]  in_v;
  logic [1:0]   in_idx;
  logic         in_rdy;
  logic [3:0]   out_ena;
  logic [127:0] out_v;
  logic [3:0]   out_rdy;
  logic         dropped;
  logic [15:0]  drop_count;

  logic         in_ena3;
  logic [31:0]  in_v3;
  logic [1:0]   in_idx3;
  logic         in_rdy3;
  logic [2:0]   out_ena3;
  logic [95:0]  out_v3;
  logic [2:0]   out_rdy3;
  logic         dropped3;
  logic [15:0]  drop_count3;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] sb [4][$];

  funnel_fanout_buffered #(.WIDTH(32), .FUNNEL_WIDTH(4), .IDX_WIDTH(2), .DEPTH(2)) dut (
    .CLK(CLK), .RST(RST),
    .in_enq__ENA(in_ena), .in_enq_v(in_v), .in_enq_index(in_idx), .in_enq__RDY(in_rdy),
    .out_enq__ENA(out_ena), .out_enq_v(out_v), .out_enq__RDY(out_rdy),
    .dropped(dropped), .drop_count(drop_count)
  );

  funnel_fanout_buffered #(.WIDTH(32), .FUNNEL_WIDTH(3), .IDX_WIDTH(2), .DEPTH(2)) dut3 (
    .CLK(CLK), .RST(RST),
    .in_enq__ENA(in_ena3), .in_enq_v(in_v3), .in_enq_index(in_idx3), .in_enq__RDY(in_rdy3),
    .out_enq__ENA(out_ena3), .out_enq_v(out_v3), .out_enq__RDY(out_rdy3),
    .dropped(dropped3), .drop_count(drop_count3)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int pending();
    return sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size();
  endfunction

  // Output monitor: every strobe must be legal and carry the oldest expected word of its lane.
  always @(negedge CLK) begin
    for (int i = 0; i < 4; i++) begin
      if (out_ena[i]) begin
        check_eq($sformatf("ena_needs_rdy%0d", i), {31'd0, out_rdy[i]}, 32'd1);
        if (sb[i].size() == 0) begin
          check_eq($sformatf("unexpected_lane%0d", i), out_v[i*32 +: 32], 32'hFFFF_FFFF);
        end else begin
          check_eq($sformatf("lane%0d_data", i), out_v[i*32 +: 32], sb[i].pop_front());
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
  task automatic enq(input logic [31:0] v, input logic [1:0] idx);
    int n = 0;
    while (!in_rdy && n < 50) begin
      @(posedge CLK); #1;
      n++;
    end
    if (!in_rdy) begin
      check_eq("enq_timeout", {31'd0, in_rdy}, 32'd1);
    end else begin
      in_ena = 1'b1;
      in_v   = v;
      in_idx = idx;
      sb[idx].push_back(v);
      @(posedge CLK); #1;
      in_ena = 1'b0;
    end
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while (pending() != 0 && n < budget) begin
      @(posedge CLK); #1;
      n++;
    end
    check_eq(tag, pending(), 32'd0);
  endtask

  initial begin
    RST = 1'b1; in_ena = 1'b0; in_v = 32'd0; in_idx = 2'd0; out_rdy = 4'hF;
    in_ena3 = 1'b0; in_v3 = 32'd0; in_idx3 = 2'd0; out_rdy3 = 3'b111;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    check_eq("reset_in_rdy", {31'd0, in_rdy}, 32'd1);
    check_eq("reset_out_ena", {28'd0, out_ena}, 32'd0);
    check_eq("reset_dropped", {31'd0, dropped}, 32'd0);
    check_eq("reset_drop_count", {16'd0, drop_count}, 32'd0);
    @(posedge CLK); #1;

    // Basic routing: one word per lane, visible exactly one cycle after acceptance.
    for (int k = 0; k < 4; k++) begin
      logic [31:0] val;
      val = 32'h11 * (k + 1);
      enq(val, 2'(k));
      @(negedge CLK);
      check_eq($sformatf("basic_ena_lane%0d", k), {28'd0, out_ena}, 32'd1 << k);
      check_eq("basic_in_rdy", {31'd0, in_rdy}, 32'd1);
      @(posedge CLK); #1;
    end
    drain("basic_drain", 10);

    // Lane stall forces global backpressure.
    out_rdy[2] = 1'b0;
    enq(32'hA0, 2'd2);
    enq(32'hA1, 2'd2);
    @(negedge CLK);
    check_eq("stall_in_rdy_low", {31'd0, in_rdy}, 32'd0);
    check_eq("stall_no_ena", {31'd0, out_ena[2]}, 32'd0);
    @(posedge CLK); #1;
    out_rdy[2] = 1'b1;
    @(negedge CLK);
    check_eq("stall_ena_a0", {31'd0, out_ena[2]}, 32'd1);
    check_eq("stall_in_rdy_still_low", {31'd0, in_rdy}, 32'd0);
    @(negedge CLK);
    check_eq("stall_ena_a1", {31'd0, out_ena[2]}, 32'd1);
    check_eq("stall_in_rdy_recovered", {31'd0, in_rdy}, 32'd1);
    @(posedge CLK); #1;
    drain("stall_drain", 10);

    // Ordering under load with lane 0 readiness toggling.
    for (int i = 0; i < 8; i++) begin
      out_rdy[0] = i[0];
      enq(32'(i + 1), 2'(i % 2));
    end
    out_rdy = 4'hF;
    drain("order_drain", 20);

    // Same-cycle push and pop on lane 3.
    out_rdy[3] = 1'b0;
    enq(32'hB0, 2'd3);
    out_rdy[3] = 1'b1;
    enq(32'hB1, 2'd3);
    @(negedge CLK);
    check_eq("pushpop_b1_head", {31'd0, out_ena[3]}, 32'd1);
    @(posedge CLK); #1;
    @(negedge CLK);
    check_eq("pushpop_empty_after", {31'd0, out_ena[3]}, 32'd0);
    @(posedge CLK); #1;
    check_eq("pushpop_drain", pending(), 32'd0);

    // Reset while lane 1 is full; the word offered during reset must be ignored.
    out_rdy[1] = 1'b0;
    enq(32'hC0, 2'd1);
    enq(32'hC1, 2'd1);
    RST = 1'b1;
    in_ena = 1'b1; in_v = 32'h77; in_idx = 2'd0;
    @(negedge CLK);
    check_eq("rst_cycle_in_rdy", {31'd0, in_rdy}, 32'd1);
    check_eq("rst_cycle_out_ena", {28'd0, out_ena}, 32'd0);
    check_eq("rst_cycle_dropped", {31'd0, dropped}, 32'd0);
    @(posedge CLK); #1;
    RST = 1'b0; in_ena = 1'b0;
    sb[1].delete();
    @(negedge CLK);
    check_eq("post_rst_out_ena", {28'd0, out_ena}, 32'd0);
    check_eq("post_rst_in_rdy", {31'd0, in_rdy}, 32'd1);
    check_eq("post_rst_drop_count", {16'd0, drop_count}, 32'd0);
    @(posedge CLK); #1;
    out_rdy = 4'hF;
    repeat (5) @(posedge CLK);
    #1;

    // Drop path on the three-lane instance.
    in_ena3 = 1'b1; in_v3 = 32'hDEAD; in_idx3 = 2'd3;
    @(posedge CLK); #1;
    in_ena3 = 1'b0;
    @(negedge CLK);
    check_eq("drop_pulse", {31'd0, dropped3}, 32'd1);
    check_eq("drop_count_1", {16'd0, drop_count3}, 32'd1);
    check_eq("drop_no_out_ena", {29'd0, out_ena3}, 32'd0);
    @(negedge CLK);
    check_eq("drop_pulse_end", {31'd0, dropped3}, 32'd0);
    @(posedge CLK); #1;
    in_ena3 = 1'b1;
    repeat (65535) @(posedge CLK);
    #1 in_ena3 = 1'b0;
    @(negedge CLK);
    check_eq("drop_count_sat", {16'd0, drop_count3}, 32'h0000_FFFF);
    check_eq("drop_sat_no_out_ena", {29'd0, out_ena3}, 32'd0);
    check_eq("main_no_drops", {15'd0, dropped, drop_count}, 32'd0);
    check_eq("final_pending", pending(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/funnel_fanout_buffered.md
Name: funnel_fanout_buffered

Overview:
- Inverse of the buffered funnel: one enq stream carries a 32-bit word plus a lane index, and the block distributes it to one of FUNNEL_WIDTH output enq channels.
- Each output lane has its own small FIFO, so a stalled consumer does not corrupt the other lanes.
- Sits between the P2M request demarshaller and per-lane consumer FIFOs in the request path of the funnel test harness.

Parameters:
- WIDTH, 32, data width of each word.
- FUNNEL_WIDTH, 4, number of output lanes (2..16).
- IDX_WIDTH, 2, width of the lane index; must satisfy 2**IDX_WIDTH >= FUNNEL_WIDTH.
- DEPTH, 2, entries per lane FIFO (2..8).

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  synchronous, active-high reset.
- in$enq__ENA  input  1  input enq strobe; driver asserts it only while in$enq__RDY=1.
- in$enq$v  input  WIDTH  input word.
- in$enq$index  input  IDX_WIDTH  destination lane.
- in$enq__RDY  output  1  input guard.
- out$enq__ENA  output  FUNNEL_WIDTH  per-lane enq strobe; bit i belongs to lane i.
- out$enq$v  output  FUNNEL_WIDTH*WIDTH  per-lane data; lane i occupies bits [i*WIDTH +: WIDTH].
- out$enq__RDY  input  FUNNEL_WIDTH  per-lane downstream guard.
- dropped  output  1  one-cycle pulse when an accepted word carried index >= FUNNEL_WIDTH.
- drop_count  output  16  saturating count of dropped words.

Behaviour:
- Guard independence: in$enq__RDY is a function of registered state only, never of in$enq$v or in$enq$index (method guards may not depend on arguments).
  - in$enq__RDY = 1 iff every lane FIFO holds fewer than DEPTH entries.
  - It is evaluated on pre-edge state; no bypass from a same-cycle dequeue.
- Accept: in$enq__ENA=1 at edge t with index k < FUNNEL_WIDTH pushes v into lane k's FIFO tail.
- Drop: if k >= FUNNEL_WIDTH, the word is consumed and discarded.
  - dropped=1 during cycle t+1.
  - drop_count increments, saturating at 16'hFFFF.
  - No lane state changes.
- Lane output:
  - out$enq__ENA[i] = (lane i nonempty) && out$enq__RDY[i], combinational.
  - out$enq$v lane i always shows the lane i FIFO head (don't-care when empty, but must be stable while nonempty and not dequeued).
  - ENA is never asserted while RDY[i]=0.
  - ENA=1 at an edge pops lane i's head.
- Latency:
  - A word accepted at edge t appears on out$enq lane k with ENA possible in cycle t+1 (one register stage).
  - There is no combinational path from in$enq$v to out$enq$v.
- Ordering: strict FIFO order within a lane; no ordering relation between lanes.
- Simultaneous push and pop on the same lane in one cycle: allowed; occupancy is unchanged and data order is preserved.
  - If the lane was empty before the edge, the pushed word is not popped that cycle, because the head was invalid.
- Full:
  - Any lane at DEPTH forces in$enq__RDY=0 for all indices (global backpressure).
  - in$enq__RDY recovers the cycle after that lane pops.
- Pointers: per-lane read/write pointers wrap modulo DEPTH. Occupancy is kept in a separate count register (0..DEPTH), so full and empty are unambiguous for non-power-of-2 DEPTH.
- Reset (RST=1 at an edge), including mid-transfer:
  - All lane counts and pointers go to 0; drop_count=0; dropped=0.
  - out$enq__ENA=0 and in$enq__RDY=1 from the cycle after reset.
  - Buffered words are discarded.
  - in$enq__ENA is ignored in a reset cycle.
- Outputs during reset cycle: out$enq__ENA=0 (lanes empty by the next cycle), in$enq__RDY=1, dropped=0.

Test Plan:
- Basic route: after reset, enq v=32'h11 idx=0, 32'h22 idx=1, 32'h33 idx=2, 32'h44 idx=3 with all out RDY=1 -> each lane i shows ENA exactly once, one cycle after its enq, with the matching value; in$enq__RDY stays 1.
- Lane stall / global backpressure: out$enq__RDY[2]=0; enq 32'hA0, 32'hA1 to lane 2 -> in$enq__RDY=0 next cycle. Raise RDY[2] -> lane 2 emits A0 then A1 on consecutive cycles; in$enq__RDY returns to 1 the cycle after A0 pops.
- Ordering under load: 8 back-to-back enqs alternating idx 0/1 (values 1..8), lane 0 RDY toggling every cycle -> lane 0 sees 1,3,5,7 and lane 1 sees 2,4,6,8, in order; no loss or duplication.
- Simultaneous push/pop: lane 3 holding 1 entry (32'hB0), out RDY[3]=1, enq 32'hB1 idx=3 in the same cycle -> B0 pops, B1 becomes head, count stays 1, B1 emitted next cycle.
- Drop path (FUNNEL_WIDTH=3, IDX_WIDTH=2): enq idx=3 v=32'hDEAD -> dropped pulses one cycle, drop_count=1, no out ENA. Repeat 65536 times -> drop_count holds 16'hFFFF.
- Reset mid-operation: fill lane 1 to DEPTH with RDY[1]=0, assert RST one cycle -> next cycle out$enq__ENA=0, in$enq__RDY=1, drop_count=0; later raising RDY[1] produces no stale words.
